// File: rtl/mac_ofm_collector.sv
// mac_ofm_collector: receives per-lane OFM words into small FIFOs and replays them
// in strict lane order (one row = lanes 0..LANES-1) on a single valid/ready stream.
// Also tracks output_end agreement within each row and sticky nan/inf status.
module mac_ofm_collector #(
   parameter int LANES      = 8,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_flush,
   input  logic [LANES-1:0]         i_lane_valid,
   output logic [LANES-1:0]         o_lane_ready,
   input  logic [LANES*DATA_W-1:0]  i_lane_data,
   input  logic [LANES-1:0]         i_lane_output_end,
   input  logic [LANES-1:0]         i_lane_is_nan,
   input  logic [LANES-1:0]         i_lane_is_inf,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [DATA_W-1:0]        o_data,
   output logic [$clog2(LANES)-1:0] o_lane_id,
   output logic                     o_output_end,
   output logic                     o_is_nan,
   output logic                     o_is_inf,
   input  logic                     i_clear_sticky,
   output logic                     o_nan_sticky,
   output logic                     o_inf_sticky,
   output logic                     o_end_mismatch
);
   localparam int LID_W = $clog2(LANES);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = DATA_W + 3;
   localparam logic [LID_W-1:0] LAST_LANE = LID_W'(LANES - 1);

   // FIFO entry layout: {data, output_end, is_nan, is_inf}
   typedef logic [EW-1:0] entry_t;

   entry_t            mem_q [LANES][FIFO_DEPTH];
   logic [AW:0]       wp_q  [LANES];
   logic [AW:0]       rp_q  [LANES];
   logic [LANES-1:0]  full, empty, push, pop;
   logic              rdy_en_q;
   logic [LID_W-1:0]  rd_ptr_q, rd_ptr_d;
   entry_t            head;
   logic              load, is_last, row_and, row_or;
   logic              end_and_q, end_and_d, end_or_q, end_or_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [LID_W-1:0]  lid_q, lid_d;
   logic              oend_q, oend_d, nan_q, nan_d, inf_q, inf_d;
   logic              nan_st_q, nan_st_d, inf_st_q, inf_st_d, mis_q, mis_d;

   // Per-lane FIFO status and input handshake; ready is held low until the first clock after reset.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         empty[k]        = (wp_q[k] == rp_q[k]);
         full[k]         = (wp_q[k][AW] != rp_q[k][AW]) && (wp_q[k][AW-1:0] == rp_q[k][AW-1:0]);
         o_lane_ready[k] = rdy_en_q & ~full[k] & ~i_flush;
         push[k]         = i_lane_valid[k] & o_lane_ready[k];
      end
   end

   assign head    = mem_q[rd_ptr_q][rp_q[rd_ptr_q][AW-1:0]];
   assign load    = (~vld_q | i_ready) & ~empty[rd_ptr_q] & ~i_flush;
   assign is_last = (rd_ptr_q == LAST_LANE);
   assign row_and = end_and_q & head[2];
   assign row_or  = end_or_q | head[2];

   // Only the FIFO selected by the lane sequencer is ever popped.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         pop[k] = load & (rd_ptr_q == LID_W'(k));
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (push[k]) begin
            mem_q[k][wp_q[k][AW-1:0]] <= {i_lane_data[k*DATA_W +: DATA_W], i_lane_output_end[k],
                                          i_lane_is_nan[k], i_lane_is_inf[k]};
         end
      end
   end

   // FIFO pointers and the post-reset ready enable; flush empties every FIFO.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdy_en_q <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            wp_q[k] <= '0;
            rp_q[k] <= '0;
         end
      end else begin
         rdy_en_q <= 1'b1;
         for (int k = 0; k < LANES; k++) begin
            if (i_flush) begin
               wp_q[k] <= '0;
               rp_q[k] <= '0;
            end else begin
               if (push[k]) wp_q[k] <= wp_q[k] + (AW+1)'(1);
               if (pop[k])  rp_q[k] <= rp_q[k] + (AW+1)'(1);
            end
         end
      end
   end

   // Next state of the lane sequencer, output register, row trackers and sticky bits.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      end_and_d = end_and_q;
      end_or_d  = end_or_q;
      vld_d     = vld_q;
      data_d    = data_q;
      lid_d     = lid_q;
      oend_d    = oend_q;
      nan_d     = nan_q;
      inf_d     = inf_q;
      nan_st_d  = nan_st_q & ~i_clear_sticky;
      inf_st_d  = inf_st_q & ~i_clear_sticky;
      mis_d     = mis_q & ~i_clear_sticky;
      if (i_flush) begin
         rd_ptr_d  = '0;
         end_and_d = 1'b1;
         end_or_d  = 1'b0;
         vld_d     = 1'b0;
      end else if (load) begin
         vld_d    = 1'b1;
         data_d   = head[EW-1:3];
         lid_d    = rd_ptr_q;
         nan_d    = head[1];
         inf_d    = head[0];
         nan_st_d = nan_st_d | head[1];
         inf_st_d = inf_st_d | head[0];
         if (is_last) begin
            // Row complete: report end only if every lane agreed, flag any disagreement.
            oend_d    = row_and;
            mis_d     = mis_d | (row_and != row_or);
            end_and_d = 1'b1;
            end_or_d  = 1'b0;
            rd_ptr_d  = '0;
         end else begin
            oend_d    = 1'b0;
            end_and_d = row_and;
            end_or_d  = row_or;
            rd_ptr_d  = rd_ptr_q + LID_W'(1);
         end
      end else if (i_ready) begin
         vld_d = 1'b0;
      end
   end

   // State register for sequencer, output stage, row trackers and sticky status.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q  <= '0;
         end_and_q <= 1'b1;
         end_or_q  <= 1'b0;
         vld_q     <= 1'b0;
         data_q    <= '0;
         lid_q     <= '0;
         oend_q    <= 1'b0;
         nan_q     <= 1'b0;
         inf_q     <= 1'b0;
         nan_st_q  <= 1'b0;
         inf_st_q  <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         end_and_q <= end_and_d;
         end_or_q  <= end_or_d;
         vld_q     <= vld_d;
         data_q    <= data_d;
         lid_q     <= lid_d;
         oend_q    <= oend_d;
         nan_q     <= nan_d;
         inf_q     <= inf_d;
         nan_st_q  <= nan_st_d;
         inf_st_q  <= inf_st_d;
         mis_q     <= mis_d;
      end
   end

   assign o_valid        = vld_q;
   assign o_data         = data_q;
   assign o_lane_id      = lid_q;
   assign o_output_end   = oend_q;
   assign o_is_nan       = nan_q;
   assign o_is_inf       = inf_q;
   assign o_nan_sticky   = nan_st_q;
   assign o_inf_sticky   = inf_st_q;
   assign o_end_mismatch = mis_q;

endmodule

// File: tb/tb_mac_ofm_collector.sv
// Bench for mac_ofm_collector: per-lane source queues feed the DUT, a reference
// model reorders accepted words into the expected stream, a monitor checks it.
module tb_mac_ofm_collector;
   localparam int LANES      = 8;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int LID_W      = 3;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              oend;
      logic              nan;
      logic              inf;
      logic [LID_W-1:0]  lid;
   } word_t;

   logic                    clk = 1'b0;
   logic                    rstn = 1'b0;
   logic                    i_flush = 1'b0;
   logic                    i_ready = 1'b0;
   logic                    i_clear_sticky = 1'b0;
   logic [LANES-1:0]        i_lane_valid = '0;
   logic [LANES-1:0]        o_lane_ready;
   logic [LANES*DATA_W-1:0] i_lane_data = '0;
   logic [LANES-1:0]        i_lane_output_end = '0;
   logic [LANES-1:0]        i_lane_is_nan = '0;
   logic [LANES-1:0]        i_lane_is_inf = '0;
   logic                    o_valid;
   logic [DATA_W-1:0]       o_data;
   logic [LID_W-1:0]        o_lane_id;
   logic                    o_output_end, o_is_nan, o_is_inf;
   logic                    o_nan_sticky, o_inf_sticky, o_end_mismatch;

   mac_ofm_collector #(.LANES(LANES), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rstn(rstn), .i_flush(i_flush),
      .i_lane_valid(i_lane_valid), .o_lane_ready(o_lane_ready), .i_lane_data(i_lane_data),
      .i_lane_output_end(i_lane_output_end), .i_lane_is_nan(i_lane_is_nan),
      .i_lane_is_inf(i_lane_is_inf), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
      .o_lane_id(o_lane_id), .o_output_end(o_output_end), .o_is_nan(o_is_nan),
      .o_is_inf(o_is_inf), .i_clear_sticky(i_clear_sticky), .o_nan_sticky(o_nan_sticky),
      .o_inf_sticky(o_inf_sticky), .o_end_mismatch(o_end_mismatch)
   );

   always #5 clk = ~clk;

   word_t send_q [LANES][$];   // words each source lane still has to deliver
   word_t lane_q [LANES][$];   // accepted words not yet placed in the output order
   word_t exp_q[$];            // expected output stream
   int    out_cyc[$];          // cycle numbers of observed output handshakes
   int    nxt_lane = 0;
   int    row_ones = 0;
   logic  m_nan = 1'b0, m_inf = 1'b0, m_mis = 1'b0;
   int    checks = 0, errors = 0, cyc = 0;
   int    sent_cnt [LANES];
   word_t rec_w, mon_e;
   logic  hold_pend = 1'b0;
   logic [38:0] hold_snap = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference ordering: lanes are emitted strictly 0..LANES-1; a row's end flag is
   // 1 only when every lane in it said so, and mixed flags mark a mismatch.
   task automatic model_accept(input int k, input word_t w);
      word_t e;
      lane_q[k].push_back(w);
      while (lane_q[nxt_lane].size() > 0) begin
         e = lane_q[nxt_lane].pop_front();
         e.lid = LID_W'(nxt_lane);
         if (nxt_lane == LANES - 1) begin
            row_ones += int'(e.oend);
            e.oend = (row_ones == LANES);
            if (row_ones != 0 && row_ones != LANES) m_mis = 1'b1;
            row_ones = 0;
            nxt_lane = 0;
         end else begin
            row_ones += int'(e.oend);
            e.oend = 1'b0;
            nxt_lane++;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic model_flush();
      for (int k = 0; k < LANES; k++) lane_q[k].delete();
      exp_q.delete();
      nxt_lane = 0;
      row_ones = 0;
   endtask

   // Source driver: present each lane's head word, then record what the DUT accepted.
   always begin
      @(posedge clk); #1;
      for (int k = 0; k < LANES; k++) begin
         if (send_q[k].size() > 0) begin
            i_lane_valid[k]                   = 1'b1;
            i_lane_data[k*DATA_W +: DATA_W]   = send_q[k][0].data;
            i_lane_output_end[k]              = send_q[k][0].oend;
            i_lane_is_nan[k]                  = send_q[k][0].nan;
            i_lane_is_inf[k]                  = send_q[k][0].inf;
         end else begin
            i_lane_valid[k] = 1'b0;
         end
      end
      @(negedge clk); #2;
      if (i_flush) begin
         model_flush();
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (rstn && i_lane_valid[k] && o_lane_ready[k]) begin
               rec_w = send_q[k].pop_front();
               model_accept(k, rec_w);
            end
         end
      end
   end

   // Output monitor: checks every handshaken word and stability while stalled.
   always @(negedge clk) begin
      if (rstn) begin
         if (hold_pend) chk("hold_stable", 64'({o_valid, o_data, o_lane_id, o_output_end, o_is_nan, o_is_inf}), 64'(hold_snap));
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'({o_lane_id, o_data}), 64'hFFFF_FFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_word", 64'({o_data, o_lane_id, o_output_end, o_is_nan, o_is_inf}),
                   64'({mon_e.data, mon_e.lid, mon_e.oend, mon_e.nan, mon_e.inf}));
               if (mon_e.nan) m_nan = 1'b1;
               if (mon_e.inf) m_inf = 1'b1;
               out_cyc.push_back(cyc);
            end
         end
         hold_pend = o_valid && !i_ready && !i_flush;
         hold_snap = {o_valid, o_data, o_lane_id, o_output_end, o_is_nan, o_is_inf};
      end
   end

   task automatic send(input int k, input logic [DATA_W-1:0] d, input logic e, input logic n, input logic f);
      word_t w;
      w.data = d; w.oend = e; w.nan = n; w.inf = f; w.lid = '0;
      send_q[k].push_back(w);
      sent_cnt[k]++;
   endtask

   task automatic drain();
      int  n;
      logic busy;
      @(posedge clk); #1 i_ready = 1'b1;
      n = 0;
      busy = 1'b1;
      while (busy && n < 3000) begin
         @(negedge clk); #3;
         busy = (exp_q.size() != 0) || o_valid;
         for (int k = 0; k < LANES; k++) if (send_q[k].size() != 0) busy = 1'b1;
         n++;
      end
      chk("drain_timeout", 64'(busy), 64'(0));
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 i_clear_sticky = 1'b1;
      @(posedge clk); #1 i_clear_sticky = 1'b0;
      m_nan = 1'b0; m_inf = 1'b0; m_mis = 1'b0;
      #1;
   endtask

   task automatic pulse_flush();
      @(posedge clk); #1 i_flush = 1'b1;
      @(posedge clk); #1 i_flush = 1'b0;
      #1;
      chk("flush_valid", 64'(o_valid), 64'(0));
      chk("flush_ready", 64'(o_lane_ready), 64'(8'hFF));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mx;
      for (int k = 0; k < LANES; k++) sent_cnt[k] = 0;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", 64'({o_valid, o_data, o_lane_id, o_output_end, o_is_nan, o_is_inf,
                              o_nan_sticky, o_inf_sticky, o_end_mismatch}), 64'(0));
      chk("rst_ready", 64'(o_lane_ready), 64'(0));
      @(posedge clk); #1 rstn = 1'b1;
      #1 chk("ready_after_release", 64'(o_lane_ready), 64'(0));
      @(posedge clk); #2 chk("ready_first_clock", 64'(o_lane_ready), 64'(8'hFF));

      // One full row, output_end everywhere, no backpressure
      i_ready = 1'b1;
      @(negedge clk);
      out_cyc.delete();
      for (int k = 0; k < LANES; k++) send(k, 32'h100 + k, 1'b1, 1'b0, 1'b0);
      drain();
      chk("row_count", 64'(out_cyc.size()), 64'(8));
      if (out_cyc.size() == 8) chk("row_back_to_back", 64'(out_cyc[7] - out_cyc[0]), 64'(7));
      chk("row_no_mismatch", 64'(o_end_mismatch), 64'(0));

      // Lane 3 withheld: stream stalls after lane 2, never skips it
      @(negedge clk);
      out_cyc.delete();
      for (int k = 0; k < LANES; k++) if (k != 3) send(k, 32'h200 + k, 1'b1, 1'b0, 1'b0);
      repeat (12) @(negedge clk);
      #3;
      chk("stall_count", 64'(out_cyc.size()), 64'(3));
      chk("stall_valid", 64'(o_valid), 64'(0));
      send(3, 32'h3, 1'b1, 1'b0, 1'b0);
      drain();
      chk("resume_count", 64'(out_cyc.size()), 64'(8));

      // Downstream backpressure fills every FIFO, then releases
      @(posedge clk); #1 i_ready = 1'b0;
      out_cyc.delete();
      for (int r = 0; r < FIFO_DEPTH + 1; r++)
         for (int k = 0; k < LANES; k++) send(k, 32'h3000 + r * 16 + k, 1'b1, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      #3;
      chk("bp_ready_low", 64'(o_lane_ready), 64'(0));
      chk("bp_valid", 64'(o_valid), 64'(1));
      chk("bp_data", 64'(o_data), 64'(32'h3000));
      drain();
      chk("bp_count", 64'(out_cyc.size()), 64'((FIFO_DEPTH + 1) * LANES));

      // Lane 5 disagrees on output_end
      @(negedge clk);
      for (int k = 0; k < LANES; k++) send(k, 32'h400 + k, (k != 5), 1'b0, 1'b0);
      drain();
      chk("mismatch_set", 64'(o_end_mismatch), 64'(1));
      pulse_clear();
      chk("mismatch_clear", 64'(o_end_mismatch), 64'(0));

      // NaN on lane 2 sets the sticky flag
      @(negedge clk);
      for (int k = 0; k < LANES; k++) send(k, 32'h500 + k, 1'b1, (k == 2), 1'b0);
      drain();
      chk("nan_sticky", 64'(o_nan_sticky), 64'(1));
      chk("inf_sticky_quiet", 64'(o_inf_sticky), 64'(0));
      pulse_clear();
      chk("nan_clear", 64'(o_nan_sticky), 64'(0));

      // Clear in the very cycle the lane-2 NaN word loads: the set must win
      @(negedge clk);
      for (int k = 0; k < LANES; k++) send(k, 32'h600 + k, 1'b1, (k == 2), 1'b0);
      @(posedge clk);   // head words presented
      @(posedge clk);   // accepted into FIFOs
      @(posedge clk);   // lane 0 loads
      @(posedge clk);   // lane 1 loads
      #1 i_clear_sticky = 1'b1;
      @(posedge clk);   // lane 2 loads together with the clear
      #1 i_clear_sticky = 1'b0;
      #1 chk("nan_set_wins", 64'(o_nan_sticky), 64'(1));
      drain();
      pulse_clear();

      // Flush mid-row after lanes 0-3 emitted; next row restarts at lane 0
      @(negedge clk);
      out_cyc.delete();
      for (int k = 0; k < LANES; k++) if (k != 4) send(k, 32'h700 + k, 1'b1, 1'b0, 1'b0);
      repeat (12) @(negedge clk);
      #3 chk("pre_flush_count", 64'(out_cyc.size()), 64'(4));
      pulse_flush();
      // Flush while a word is held in the output register
      i_ready = 1'b0;
      for (int k = 0; k < LANES; k++) send(k, 32'h800 + k, 1'b1, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      #3 chk("held_before_flush", 64'(o_valid), 64'(1));
      pulse_flush();
      out_cyc.delete();
      @(negedge clk);
      for (int k = 0; k < LANES; k++) send(k, 32'h900 + k, 1'b1, 1'b0, 1'b0);
      drain();
      chk("post_flush_count", 64'(out_cyc.size()), 64'(8));
      chk("post_flush_no_mismatch", 64'(o_end_mismatch), 64'(0));

      // Randomised traffic with random backpressure, flags and end bits
      for (int c = 0; c < 600; c++) begin
         int k;
         @(posedge clk); #1;
         i_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, LANES - 1);
            if (send_q[k].size() < 3)
               send(k, $urandom, ($urandom_range(0, 9) != 0), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 31) == 0));
         end
      end
      mx = 0;
      for (int k = 0; k < LANES; k++) if (sent_cnt[k] > mx) mx = sent_cnt[k];
      for (int k = 0; k < LANES; k++)
         while (sent_cnt[k] < mx) send(k, $urandom, 1'b1, 1'b0, 1'b0);
      drain();
      chk("rand_nan_sticky", 64'(o_nan_sticky), 64'(m_nan));
      chk("rand_inf_sticky", 64'(o_inf_sticky), 64'(m_inf));
      chk("rand_mismatch", 64'(o_end_mismatch), 64'(m_mis));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_ofm_collector.md
Name: mac_ofm_collector

Overview:
- Receiving end of the per-lane OFM interface (32-bit data plus output_end, with nan/inf monitor flags) for one lane group of MAC lanes.
- Buffers each lane's results in a small FIFO and re-serialises them in strict lane order (lane 0..LANES-1 = one output row) onto a single valid/ready stream toward the OFM writeback path.
- Checks end-of-output alignment across lanes and keeps sticky nan/inf/mismatch status.

Parameters:
- LANES, 8, lanes per group (equals MAC_LANE_GROUP).
- DATA_W, 32, lane OFM data width.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush of FIFOs, pointer, row tracking and output register
- i_lane_valid  in  LANES  per-lane OFM word valid
- o_lane_ready  out  LANES  per-lane ready (that lane's FIFO not full and no flush)
- i_lane_data  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
- i_lane_output_end  in  LANES  per-lane output_end
- i_lane_is_nan  in  LANES  per-lane monitor is_nan
- i_lane_is_inf  in  LANES  per-lane monitor is_inf
- o_valid  out  1  output word valid
- i_ready  in  1  downstream ready
- o_data  out  DATA_W  output word
- o_lane_id  out  $clog2(LANES)  source lane of o_data
- o_output_end  out  1  last word of the OFM tile (only on lane LANES-1 words)
- o_is_nan  out  1  nan flag carried with o_data
- o_is_inf  out  1  inf flag carried with o_data
- i_clear_sticky  in  1  clears sticky status
- o_nan_sticky  out  1  any nan emitted since the last clear
- o_inf_sticky  out  1  any inf emitted since the last clear
- o_end_mismatch  out  1  sticky: lanes in one row disagreed on output_end

Behaviour:
- Reset (rstn=0, asynchronous): all FIFOs empty, rd_ptr=0, row trackers cleared, every output 0, including o_lane_ready.
  - o_lane_ready goes to 1 on the first clock after reset is released.
- Input handshake: a lane word transfers when i_lane_valid[k] & o_lane_ready[k].
  - The FIFO entry stores {data, output_end, is_nan, is_inf}.
  - o_lane_ready[k] = !full[k] & !i_flush; this is combinational from FIFO state.
  - A write and a read on the same full FIFO in the same cycle is not allowed, because ready is already low.
- Sequencing: rd_ptr cycles 0..LANES-1 and wraps to 0. Only FIFO[rd_ptr] may be popped. An empty FIFO at rd_ptr stalls the output; lanes are never skipped.
- Output register (single stage):
  - Load condition: (!o_valid | i_ready) & !empty[rd_ptr].
  - On load: pop FIFO[rd_ptr], register its fields, set o_lane_id=rd_ptr, advance rd_ptr.
  - If o_valid & i_ready and no load occurs, o_valid drops to 0.
  - While o_valid & !i_ready, all outputs hold stable.
- Latency: a word accepted on edge N can be visible with o_valid=1 after edge N+1 (2-cycle minimum).
  - Sustained throughput is 1 word/cycle when all FIFOs hold data and i_ready=1.
- Row tracking: over each row, keep end_and (AND of output_end) and end_or (OR of output_end).
  - On the load of the lane LANES-1 word: o_output_end = end_and including that word.
  - If end_and != end_or, set o_end_mismatch.
  - Trackers reset to the all-and=1 / or=0 state after that load.
  - On lanes other than LANES-1, o_output_end is always 0.
- Sticky flags:
  - o_nan_sticky and o_inf_sticky set when a word carrying that flag is loaded into the output register.
  - i_clear_sticky clears all three sticky bits. If a set and a clear occur in the same cycle, the set wins.
- i_flush, for one cycle:
  - Empties all FIFOs, sets rd_ptr=0, resets the row trackers, sets o_valid=0.
  - Input words presented during that cycle are dropped.
  - Sticky flags are unaffected.
  - Flush has priority over simultaneous load and pop.
- Reset mid-stream: all state is lost immediately; no partial row is emitted after release.

Test Plan:
- Lanes 0..7 each send one word 0x100+k with output_end=1, i_ready=1 -> 8 outputs on consecutive cycles, lane_id 0..7, o_output_end=1 only with lane_id 7, o_end_mismatch=0.
- Lane 3 withheld while lanes 0-2 and 4-7 are valid -> outputs for lanes 0,1,2 appear, then the stream stalls. Lane 3 sends 0x3 -> outputs resume with lane 3, then lanes 4-7.
- i_ready=0 with all lanes streaming -> after the FIFOs fill, o_lane_ready=0 on every lane, o_data holds stable, no data is lost. Releasing i_ready yields FIFO_DEPTH+1 rows in order.
- Lane 5 sends output_end=0 while the others send 1 -> the lane 7 output has o_output_end=0 and o_end_mismatch=1 (sticky). i_clear_sticky -> 0.
- Lane 2 word with is_nan=1 -> o_is_nan=1 on that word and o_nan_sticky=1. Asserting i_clear_sticky in the same cycle as a new nan load leaves o_nan_sticky=1.
- i_flush mid-row (after lanes 0-3 emitted) -> o_valid=0 next cycle, FIFOs empty. The next full row starts at lane_id 0; no mismatch is flagged.
